io_bridge: RTL and testbench

Byte-stream-to-IO-bus initiator. It accepts command bytes from a host channel (UART receiver, debug port), decodes them, and drives the 8-bit memory-mapped IO bus (address / write data / write enable / read enable / read data) as master. Read data and status return on an outbound byte stream. It is the counterpart to the IO peripheral responder (GPIO, counter/timer) and lets an external host poke the IO map without the CPU.

---
 rtl/io_bridge_pkg.sv | 37 +++
 rtl/io_bridge_timeout.sv | 44 ++++
 rtl/io_bridge.sv | 176 +++++++++++++++++
 tb/tb_io_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared opcode/response constants and the bridge state
// encoding for the byte-stream-to-IO-bus initiator.
// Optional feature macro used by the bridge: IO_BRIDGE_WACK_EN.
package io_bridge_pkg;

    // Command opcodes arriving on the host byte stream
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    // Response bytes returned on the outbound stream
    localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'
    localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'

    // Width of the inter-byte timeout counter
    localparam int unsigned TMO_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RWAIT,
        ST_RESP
    } state_t;

    // States in which the bridge is willing to take a byte from the host
    function automatic logic rx_open(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

    // States in which a partially received command can time out
    function automatic logic mid_command(input state_t s);
        return (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/io_bridge_timeout.sv
// io_bridge_timeout: 24-bit inter-byte timer. Counts enabled cycles since the
// last clear; expired_o marks the cycle whose closing edge brings the count to
// TIMEOUT. TIMEOUT = 0 disables expiry entirely.
module io_bridge_timeout
    import io_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LIMIT   = TMO_W'(TIMEOUT - 1);
    localparam logic             ENABLED = (TIMEOUT != 0);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled and saturate
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is judged on the count reached at the coming edge
    assign expired_o = ENABLED && en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/io_bridge.sv
// io_bridge: host byte stream to 8-bit IO bus master.
//   0x57 addr data -> one-cycle io_w_en
//   0x52 addr      -> one-cycle io_r_en, read data returned on tx
//   other opcode   -> 0x3F returned on tx
// Build option IO_BRIDGE_WACK_EN: each completed write answers 0x4B.
// All outputs are registered; they are loaded from the next-state decode.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] io_address,
    output logic [7:0] io_wdata,
    output logic       io_w_en,
    output logic       io_r_en,
    input  logic [7:0] io_rdata,
    output logic       busy
);

    // Last RWAIT cycle index; RD_LATENCY is limited to 1..4
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t     state_q,      state_d;
    logic       is_read_q,    is_read_d;
    logic [1:0] lat_q,        lat_d;
    logic [7:0] io_address_q, io_address_d;
    logic [7:0] io_wdata_q,   io_wdata_d;
    logic [7:0] tx_data_q,    tx_data_d;
    logic       io_w_en_q;
    logic       io_r_en_q;
    logic       tx_valid_q;
    logic       rx_ready_q;
    logic       busy_q;

    logic       accept;
    logic       tmo_expired;

    assign accept = rx_valid && rx_ready_q;

    io_bridge_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept || !mid_command(state_q)),
        .en_i      (mid_command(state_q)),
        .expired_o (tmo_expired)
    );

    // Command decode and bus sequencing: next state and data registers
    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        lat_d        = lat_q;
        io_address_d = io_address_q;
        io_wdata_d   = io_wdata_q;
        tx_data_d    = tx_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (rx_data == OP_WRITE) begin
                        is_read_d = 1'b0;
                        state_d   = ST_ADDR;
                    end else if (rx_data == OP_READ) begin
                        is_read_d = 1'b1;
                        state_d   = ST_ADDR;
                    end else begin
                        tx_data_d = RSP_BAD;
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (accept) begin
                    io_address_d = rx_data;
                    state_d      = is_read_q ? ST_RD : ST_DATA;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (accept) begin
                    io_wdata_d = rx_data;
                    state_d    = ST_WR;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
`ifdef IO_BRIDGE_WACK_EN
                tx_data_d = RSP_ACK;
                state_d   = ST_RESP;
`else
                state_d   = ST_IDLE;
`endif
            end

            ST_RD: begin
                lat_d   = '0;
                state_d = ST_RWAIT;
            end

            ST_RWAIT: begin
                if (lat_q == LAT_LAST) begin
                    tx_data_d = io_rdata;
                    state_d   = ST_RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (tx_valid_q && tx_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and registered strobes; strobes decode the upcoming state
    // so each output is valid for the whole cycle the state occupies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            is_read_q    <= 1'b0;
            lat_q        <= '0;
            io_address_q <= '0;
            io_wdata_q   <= '0;
            tx_data_q    <= '0;
            io_w_en_q    <= 1'b0;
            io_r_en_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_read_q    <= is_read_d;
            lat_q        <= lat_d;
            io_address_q <= io_address_d;
            io_wdata_q   <= io_wdata_d;
            tx_data_q    <= tx_data_d;
            io_w_en_q    <= (state_d == ST_WR);
            io_r_en_q    <= (state_d == ST_RD);
            tx_valid_q   <= (state_d == ST_RESP);
            rx_ready_q   <= rx_open(state_d);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign io_address = io_address_q;
    assign io_wdata   = io_wdata_q;
    assign io_w_en    = io_w_en_q;
    assign io_r_en    = io_r_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed test of io_bridge (default build, IO_BRIDGE_WACK_EN
// undefined) with TIMEOUT=16 and a registered-read responder model.
module tb_io_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] io_address;
    logic [7:0] io_wdata;
    logic       io_w_en;
    logic       io_r_en;
    logic [7:0] io_rdata;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int xfer_cnt = 0;
    int both_hi = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    io_bridge #(
        .RD_LATENCY (1),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .io_address (io_address),
        .io_wdata   (io_wdata),
        .io_w_en    (io_w_en),
        .io_r_en    (io_r_en),
        .io_rdata   (io_rdata),
        .busy       (busy)
    );

    // Responder model: registered read data, two preset locations
    always @(posedge clk) begin
        if (rst) begin
            mem[3]   <= 8'hC3;
            mem[6]   <= 8'h3C;
            io_rdata <= 8'h00;
        end else begin
            if (io_w_en) mem[io_address] <= io_wdata;
            if (io_r_en) io_rdata <= mem[io_address];
        end
    end

    // Bus and tx activity counters
    always @(posedge clk) begin
        if (!rst) begin
            if (io_w_en) wr_cnt <= wr_cnt + 1;
            if (io_r_en) rd_cnt <= rd_cnt + 1;
            if (io_w_en && io_r_en) both_hi <= both_hi + 1;
            if (tx_valid && tx_ready) xfer_cnt <= xfer_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for a response, check it, then take it with a one-cycle tx_ready
    task automatic take_resp(input string tag, input logic [7:0] exp);
        int unsigned n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(tx_valid), 1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        check({tag, "_released"}, 32'(tx_valid), 0);
    endtask

    initial begin
        int w0, r0, x0, bad;

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_strobes", {30'd0, io_w_en, io_r_en}, 0);
        check("rst_addr", 32'(io_address), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", 32'(rx_ready), 1);

        // Write 0x57 0x01 0xA5
        w0 = wr_cnt;
        send(8'h57);
        send(8'h01);
        send(8'hA5);
        check("wr_w_en", 32'(io_w_en), 1);
        check("wr_addr", 32'(io_address), 32'h01);
        check("wr_wdata", 32'(io_wdata), 32'hA5);
        check("wr_rx_ready_low", 32'(rx_ready), 0);
        @(negedge clk);
        check("wr_w_en_off", 32'(io_w_en), 0);
        check("wr_rx_ready_back", 32'(rx_ready), 1);
        check("wr_busy_off", 32'(busy), 0);
        check("wr_no_tx", 32'(tx_valid), 0);
        check("wr_pulses", 32'(wr_cnt - w0), 1);

        // Read 0x52 0x06 -> 0x3C
        r0 = rd_cnt;
        send(8'h52);
        send(8'h06);
        check("rd_r_en", 32'(io_r_en), 1);
        check("rd_addr", 32'(io_address), 32'h06);
        @(negedge clk);
        check("rd_r_en_off", 32'(io_r_en), 0);
        check("rd_tx_not_yet", 32'(tx_valid), 0);
        @(negedge clk);
        check("rd_tx_timing", 32'(tx_valid), 1);
        take_resp("rd", 8'h3C);
        check("rd_pulses", 32'(rd_cnt - r0), 1);

        // Bad opcode, then a read of the earlier write
        w0 = wr_cnt;
        r0 = rd_cnt;
        send(8'h10);
        check("bad_tx_timing", 32'(tx_valid), 1);
        check("bad_rx_ready", 32'(rx_ready), 0);
        take_resp("bad", 8'h3F);
        check("bad_no_bus", 32'((wr_cnt - w0) + (rd_cnt - r0)), 0);
        check("bad_idle", 32'(busy), 0);
        send(8'h52);
        send(8'h01);
        take_resp("rd_after_bad", 8'hA5);

        // Timeout after 0x57 0x02
        w0 = wr_cnt;
        send(8'h57);
        send(8'h02);
        repeat (15) @(negedge clk);
        check("tmo_busy_15", 32'(busy), 1);
        @(negedge clk);
        check("tmo_busy_16", 32'(busy), 0);
        check("tmo_rx_ready", 32'(rx_ready), 1);
        repeat (4) @(negedge clk);
        check("tmo_no_write", 32'(wr_cnt - w0), 0);
        check("tmo_no_tx", 32'(tx_valid), 0);
        send(8'hA5);
        take_resp("tmo_fresh_opcode", 8'h3F);
        check("tmo_fresh_no_write", 32'(wr_cnt - w0), 0);

        // Backpressure on a read of 0x06
        x0 = wr_cnt;  // reused as a scratch baseline below
        x0 = xfer_cnt;
        send(8'h52);
        send(8'h06);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!tx_valid || tx_data != 8'h3C || rx_ready) bad++;
            @(negedge clk);
        end
        check("bp_stable_cycles", 32'(bad), 0);
        check("bp_no_xfer", 32'(xfer_cnt - x0), 0);
        take_resp("bp", 8'h3C);
        check("bp_one_xfer", 32'(xfer_cnt - x0), 1);

        // Reset mid-command, then a clean read of 0x03
        w0 = wr_cnt;
        send(8'h57);
        send(8'h03);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rx_ready", 32'(rx_ready), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_addr", 32'(io_address), 0);
        check("mid_rst_wdata", 32'(io_wdata), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0 = rd_cnt;
        send(8'h52);
        send(8'h03);
        take_resp("post_rst_rd", 8'hC3);
        check("post_rst_no_write", 32'(wr_cnt - w0), 0);
        check("post_rst_rd_pulses", 32'(rd_cnt - r0), 1);

        check("strobe_exclusive", 32'(both_hi), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
